// File: rtl/dma_writer.sv
// -----------------------------------------------------------------------------
// dma_writer
//
// Copies a run of words from a wide parallel source buffer into a small
// word-addressed memory, one word per clock. The transfer parameters and the
// source words are captured when a request is accepted. After that, the
// request inputs may change freely until the transfer completes.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-low reset
//   i_write      transfer request (level), held until o_ready is seen
//   i_address    base memory address of the transfer
//   i_count      number of words to write (clamped to BUFFER_SIZE)
//   i_buffer     source words, word k at bits [k*WORD_SIZE +: WORD_SIZE]
//   o_mem_addr   memory write address (holds its value between writes)
//   o_mem_data   memory write data    (holds its value between writes)
//   o_mem_write  memory write strobe
//   o_ready      transfer complete; cleared once i_write drops
// -----------------------------------------------------------------------------
module dma_writer #(
    parameter int BUFFER_SIZE       = 120,
    parameter int WORD_SIZE         = 16,
    parameter int MEM_ADDRESS_WIDTH = 3
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                i_write,
    input  logic [MEM_ADDRESS_WIDTH-1:0]        i_address,
    input  logic [MEM_ADDRESS_WIDTH-1:0]        i_count,
    input  logic [BUFFER_SIZE*WORD_SIZE-1:0]    i_buffer,
    output logic [MEM_ADDRESS_WIDTH-1:0]        o_mem_addr,
    output logic [WORD_SIZE-1:0]                o_mem_data,
    output logic                                o_mem_write,
    output logic                                o_ready
);

    // i_count cannot exceed 2^AW-1. Only that many leading words can ever
    // be written, so only those words are captured.
    localparam int MAX_WORDS = (BUFFER_SIZE < (2**MEM_ADDRESS_WIDTH) - 1) ?
                               BUFFER_SIZE : (2**MEM_ADDRESS_WIDTH) - 1;
    localparam logic [MEM_ADDRESS_WIDTH-1:0] MAX_CNT = MAX_WORDS[MEM_ADDRESS_WIDTH-1:0];

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                         state_q, state_d;
    logic [MEM_ADDRESS_WIDTH-1:0]   base_q,  base_d;
    logic [MEM_ADDRESS_WIDTH-1:0]   cnt_q,   cnt_d;
    logic [MEM_ADDRESS_WIDTH-1:0]   idx_q,   idx_d;
    logic [MEM_ADDRESS_WIDTH-1:0]   addr_q,  addr_d;
    logic [WORD_SIZE-1:0]           data_q,  data_d;
    logic                           wr_q,    wr_d;
    logic                           ready_q, ready_d;

    logic [WORD_SIZE-1:0]           buf_q [MAX_WORDS];
    logic [WORD_SIZE-1:0]           buf_d [MAX_WORDS];
    logic                           latch;
    logic [MEM_ADDRESS_WIDTH-1:0]   clamp_cnt;
    logic [WORD_SIZE-1:0]           next_word;

    // Source word capture on request acceptance
    generate
        for (genvar gi = 0; gi < MAX_WORDS; gi++) begin : g_buf
            assign buf_d[gi] = latch ? i_buffer[gi*WORD_SIZE +: WORD_SIZE] : buf_q[gi];
        end
        if (BUFFER_SIZE > MAX_WORDS) begin : g_tail
            // Words beyond the largest expressible count are never written.
            logic unused_tail;
            assign unused_tail = ^i_buffer[BUFFER_SIZE*WORD_SIZE-1 : MAX_WORDS*WORD_SIZE];
        end
    endgenerate

    // Data-only storage: no reset needed, contents are always loaded
    // before they are read.
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

    assign clamp_cnt = (i_count > MAX_CNT) ? MAX_CNT : i_count;

    always_comb begin
        next_word = '0;
        for (int i = 0; i < MAX_WORDS; i++) begin
            if (idx_q == i[MEM_ADDRESS_WIDTH-1:0]) begin
                next_word = buf_q[i];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        data_d  = data_q;
        wr_d    = wr_q;
        ready_d = ready_q;
        latch   = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_write) begin
                    latch  = 1'b1;
                    base_d = i_address;
                    cnt_d  = clamp_cnt;
                    if (clamp_cnt != '0) begin
                        // Word 0 goes straight from the input so that the
                        // first strobe appears right after acceptance.
                        state_d = WRITE;
                        wr_d    = 1'b1;
                        addr_d  = i_address;
                        data_d  = i_buffer[WORD_SIZE-1:0];
                        idx_d   = {{(MEM_ADDRESS_WIDTH-1){1'b0}}, 1'b1};
                    end else begin
                        state_d = DONE;
                        ready_d = 1'b1;
                        idx_d   = '0;
                    end
                end
            end
            WRITE: begin
                if (idx_q < cnt_q) begin
                    // Address wraps naturally through the truncating add.
                    addr_d = base_q + idx_q;
                    data_d = next_word;
                    idx_d  = idx_q + 1'b1;
                end else begin
                    state_d = DONE;
                    wr_d    = 1'b0;
                    ready_d = 1'b1;
                end
            end
            DONE: begin
                if (!i_write) begin
                    state_d = IDLE;
                    ready_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                wr_d    = 1'b0;
                ready_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            base_q  <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            wr_q    <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            wr_q    <= wr_d;
            ready_q <= ready_d;
        end
    end

    assign o_mem_addr  = addr_q;
    assign o_mem_data  = data_q;
    assign o_mem_write = wr_q;
    assign o_ready     = ready_q;

endmodule

// File: tb/tb_dma_writer.sv
// -----------------------------------------------------------------------------
// tb_dma_writer
//
// Drives directed and randomized transfers into dma_writer. A behavioural
// memory captures the strobes. The expected memory image and strobe
// sequence are derived from the transfer rules: word k goes to
// (base+k) mod 2^AW, one word per cycle.
// -----------------------------------------------------------------------------
module tb_dma_writer;

    localparam int BS    = 120;
    localparam int WS    = 16;
    localparam int AW    = 3;
    localparam int DEPTH = 2**AW;

    logic              clk;
    logic              reset;
    logic              i_write;
    logic [AW-1:0]     i_address;
    logic [AW-1:0]     i_count;
    logic [BS*WS-1:0]  i_buffer;
    logic [AW-1:0]     o_mem_addr;
    logic [WS-1:0]     o_mem_data;
    logic              o_mem_write;
    logic              o_ready;

    int checks = 0;
    int errors = 0;
    int strobes = 0;

    logic [WS-1:0] mem     [DEPTH];
    logic [WS-1:0] exp_mem [DEPTH];

    dma_writer #(
        .BUFFER_SIZE       (BS),
        .WORD_SIZE         (WS),
        .MEM_ADDRESS_WIDTH (AW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .i_write     (i_write),
        .i_address   (i_address),
        .i_count     (i_count),
        .i_buffer    (i_buffer),
        .o_mem_addr  (o_mem_addr),
        .o_mem_data  (o_mem_data),
        .o_mem_write (o_mem_write),
        .o_ready     (o_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural target memory plus strobe counter
    always @(posedge clk) begin
        if (o_mem_write === 1'b1) begin
            mem[o_mem_addr] <= o_mem_data;
            strobes <= strobes + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_mem(input string tag);
        for (int a = 0; a < DEPTH; a++) begin
            check($sformatf("%s_mem%0d", tag, a), 32'(mem[a]), 32'(exp_mem[a]));
        end
    endtask

    task automatic load_buffer(input bit ramp);
        for (int w = 0; w < BS; w++) begin
            i_buffer[w*WS +: WS] = ramp ? WS'(10 + w) : WS'($urandom);
        end
    endtask

    // One full transfer: request, per-cycle strobe checks, completion and
    // handshake, then strobe count and memory image.
    task automatic run_xfer(input string tag, input int base, input int cnt,
                            input bit churn, input int hold, input bit ramp);
        logic [BS*WS-1:0] snap;
        int s0;
        int n;
        int last;
        @(negedge clk);
        load_buffer(ramp);
        i_address = AW'(base);
        i_count   = AW'(cnt);
        i_write   = 1'b1;
        snap      = i_buffer;
        s0        = strobes;
        n         = (cnt > BS) ? BS : cnt;
        @(posedge clk); #1;
        if (churn) begin
            i_address = AW'(5);
            i_count   = AW'(1);
            i_buffer  = ~i_buffer;
            i_write   = 1'b0;
        end
        for (int k = 0; k < n; k++) begin
            check($sformatf("%s_wr%0d", tag, k), 32'(o_mem_write), 32'd1);
            check($sformatf("%s_addr%0d", tag, k), 32'(o_mem_addr), (base + k) % DEPTH);
            check($sformatf("%s_data%0d", tag, k), 32'(o_mem_data), 32'(snap[k*WS +: WS]));
            check($sformatf("%s_rdy%0d", tag, k), 32'(o_ready), 32'd0);
            exp_mem[(base + k) % DEPTH] = snap[k*WS +: WS];
            @(posedge clk); #1;
        end
        check({tag, "_done_wr"}, 32'(o_mem_write), 32'd0);
        check({tag, "_done_rdy"}, 32'(o_ready), 32'd1);
        if (n > 0) begin
            last = n - 1;
            check({tag, "_hold_addr"}, 32'(o_mem_addr), (base + last) % DEPTH);
            check({tag, "_hold_data"}, 32'(o_mem_data), 32'(snap[last*WS +: WS]));
        end
        if (churn) begin
            @(posedge clk); #1;
            check({tag, "_pulse_rdy"}, 32'(o_ready), 32'd0);
        end else begin
            for (int h = 0; h < hold; h++) begin
                @(posedge clk); #1;
                check($sformatf("%s_hold_rdy%0d", tag, h), 32'(o_ready), 32'd1);
                check($sformatf("%s_hold_wr%0d", tag, h), 32'(o_mem_write), 32'd0);
            end
            i_write = 1'b0;
            @(posedge clk); #1;
            check({tag, "_release_rdy"}, 32'(o_ready), 32'd0);
        end
        check({tag, "_wr_idle"}, 32'(o_mem_write), 32'd0);
        check({tag, "_strobes"}, 32'(strobes - s0), 32'(n));
        check_mem(tag);
        $display("xfer %s base=%0d count=%0d churn=%0d hold=%0d done", tag, base, cnt, churn, hold);
    endtask

    initial begin
        logic [BS*WS-1:0] snap;
        int s0;
        int base;

        reset     = 1'b0;
        i_write   = 1'b0;
        i_address = '0;
        i_count   = '0;
        i_buffer  = '0;
        for (int a = 0; a < DEPTH; a++) begin
            mem[a]     = '0;
            exp_mem[a] = '0;
        end

        repeat (2) @(posedge clk);
        #1;
        check("rst_wr",   32'(o_mem_write), 32'd0);
        check("rst_rdy",  32'(o_ready),     32'd0);
        check("rst_addr", 32'(o_mem_addr),  32'd0);
        check("rst_data", 32'(o_mem_data),  32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Directed cases
        run_xfer("basic", 1, 4, 1'b0, 0, 1'b1);
        run_xfer("wrap",  6, 4, 1'b0, 0, 1'b0);
        run_xfer("zero",  int'($urandom_range(0, DEPTH-1)), 0, 1'b0, 2, 1'b0);
        run_xfer("churn", 2, 4, 1'b1, 0, 1'b0);
        run_xfer("hshk",  3, 3, 1'b0, 5, 1'b0);
        run_xfer("retrig", int'($urandom_range(0, DEPTH-1)), 7, 1'b0, 0, 1'b0);

        // Randomized transfers
        for (int t = 0; t < 8; t++) begin
            run_xfer($sformatf("rnd%0d", t),
                     int'($urandom_range(0, DEPTH-1)),
                     int'($urandom_range(0, DEPTH-1)),
                     1'($urandom_range(0, 1)),
                     int'($urandom_range(0, 3)), 1'b0);
        end

        // Reset in the middle of a 6-word transfer after two strobes
        @(negedge clk);
        load_buffer(1'b0);
        base      = int'($urandom_range(0, DEPTH-1));
        i_address = AW'(base);
        i_count   = AW'(6);
        i_write   = 1'b1;
        snap      = i_buffer;
        s0        = strobes;
        @(posedge clk); #1;
        check("mid_wr0", 32'(o_mem_write), 32'd1);
        @(posedge clk); #1;
        check("mid_wr1", 32'(o_mem_write), 32'd1);
        @(posedge clk); #1;
        exp_mem[base % DEPTH]       = snap[0 +: WS];
        exp_mem[(base + 1) % DEPTH] = snap[WS +: WS];
        #2;
        reset   = 1'b0;
        i_write = 1'b0;
        #1;
        check("mid_async_wr",   32'(o_mem_write), 32'd0);
        check("mid_async_rdy",  32'(o_ready),     32'd0);
        check("mid_async_addr", 32'(o_mem_addr),  32'd0);
        check("mid_async_data", 32'(o_mem_data),  32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check("mid_idle_wr",  32'(o_mem_write), 32'd0);
        check("mid_idle_rdy", 32'(o_ready),     32'd0);
        check("mid_strobes",  32'(strobes - s0), 32'd2);
        check_mem("mid");
        $display("xfer mid-reset base=%0d count=6 aborted after 2 words", base);

        // First request after reset release is accepted immediately
        run_xfer("postrst", int'($urandom_range(0, DEPTH-1)), 5, 1'b0, 1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dma_writer.md
DMA_WRITER -- requirements
Module: dma_writer

Interface
REQ-001 SHALL have parameter BUFFER_SIZE, default 120, number of words held in the source buffer.
REQ-002 SHALL have parameter WORD_SIZE, default 16, bits per word.
REQ-003 SHALL have parameter MEM_ADDRESS_WIDTH, default 3, memory address width.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port i_write  input  1  transfer request, level; held high until o_ready seen.
REQ-007 SHALL have port i_address  input  MEM_ADDRESS_WIDTH  base memory address of transfer.
REQ-008 SHALL have port i_count  input  MEM_ADDRESS_WIDTH  number of words to write.
REQ-009 SHALL have port i_buffer  input  BUFFER_SIZE x WORD_SIZE packed, index 0 first  source words.
REQ-010 SHALL have port o_mem_addr  output  MEM_ADDRESS_WIDTH  memory write address.
REQ-011 SHALL have port o_mem_data  output  WORD_SIZE  memory write data.
REQ-012 SHALL have port o_mem_write  output  1  memory write strobe; memory captures addr/data on the edge where this is high.
REQ-013 SHALL have port o_ready  output  1  transfer complete.

Function
REQ-014 SHALL implement states IDLE, WRITE, DONE; all outputs registered.
REQ-015 In IDLE with i_write=1 at edge E0, SHALL latch i_address, i_count (clamped to BUFFER_SIZE), and i_buffer into internal registers.
REQ-016 After E0 with latched count>0, SHALL enter WRITE presenting o_mem_write=1, o_mem_addr=base, o_mem_data=buf[0].
REQ-017 After edge E_k (1<=k<count), SHALL present o_mem_write=1, o_mem_addr=(base+k) mod 2^MEM_ADDRESS_WIDTH, o_mem_data=buf[k]; exactly one word per cycle, no gaps.
REQ-018 After edge E_count, SHALL enter DONE with o_mem_write=0 and o_ready=1; o_ready latency = count+1 edges from E0.
REQ-019 With latched count=0, SHALL go IDLE->DONE at E0 with no write strobe.
REQ-020 Address arithmetic SHALL wrap modulo 2^MEM_ADDRESS_WIDTH (base 6, count 4 -> addresses 6,7,0,1).
REQ-021 Changes on i_address, i_count, i_buffer, or i_write deassertion during WRITE SHALL be ignored; the transfer completes with latched values.
REQ-022 In DONE, o_ready SHALL stay 1 while i_write=1; on the first edge with i_write=0, SHALL return to IDLE with o_ready=0.
REQ-023 A new transfer SHALL start only from IDLE; i_write held high across DONE SHALL NOT retrigger.
REQ-024 o_mem_addr and o_mem_data SHALL hold their last values when o_mem_write=0 (no toggling outside WRITE).

Reset
REQ-025 reset=0 SHALL immediately, without waiting for clk, force IDLE, o_mem_write=0, o_ready=0, o_mem_addr=0, o_mem_data=0, and clear the internal index/count.
REQ-026 Reset during WRITE SHALL abort the transfer; words already strobed stay in memory; no further strobes until a new request.
REQ-027 After reset release, first request SHALL be accepted on the first rising edge with reset=1 and i_write=1.

Verification
REQ-028 Basic: memory zeroed, buffer {10,11,12,13,...}, address=1, count=4, i_write=1 -> strobes at addrs 1,2,3,4 with data 10..13 on 4 consecutive cycles, o_ready=1 five edges after E0; memory[0], memory[5..7] unchanged.
REQ-029 Wrap: address=6, count=4 -> writes memory[6]=buf0, [7]=buf1, [0]=buf2, [1]=buf3.
REQ-030 Zero count: count=0, i_write=1 -> o_ready=1 after one edge, o_mem_write never high, memory unchanged.
REQ-031 Input churn: after E0 change address to 5, count to 1, drop i_write -> still 4 writes at original addresses; o_ready pulses for one cycle then IDLE since i_write low.
REQ-032 Handshake: hold i_write=1 in DONE for 5 cycles -> o_ready stays 1, no new strobes; drop i_write -> o_ready=0 next edge; raise again -> new transfer starts.
REQ-033 Reset mid-transfer: count=6, assert reset=0 between edges after 2 strobes -> o_mem_write and o_ready drop to 0 asynchronously, only 2 words written, state IDLE on release.
